// File: rtl/icache_refill_pkg.sv
// icache_pkg: shared state encoding, line geometry and address helpers for the icache refill controller
package icache_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam int OFFSET_LSB = 2;
    localparam int OFFSET_W = 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_LSB-OFFSET_W){1'b1}}, {(OFFSET_LSB+OFFSET_W){1'b0}}};
    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base, input logic [OFFSET_W-1:0] idx);
        return base + ADDR_W'({idx, {OFFSET_LSB{1'b0}}});
    endfunction
endpackage

// File: rtl/icache_refill_if.sv
// icache_refill_if: miss, memory and fill signals of the refill controller; ICACHE_REFILL_CWF_EN adds crit_valid/crit_word
interface icache_refill_if;
    import icache_pkg::*;
    logic miss;
    logic [ADDR_W-1:0] miss_addr;
    logic mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic fill_valid;
    logic [LINE_W-1:0] fill_line;
    logic [ADDR_W-1:0] fill_addr;
    logic busy;
`ifdef ICACHE_REFILL_CWF_EN
    logic crit_valid;
    logic [WORD_W-1:0] crit_word;
    modport master (
        input miss, miss_addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy, crit_valid, crit_word
    );
    modport slave (
        output miss, miss_addr, mem_ack, mem_rdata,
        input mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy, crit_valid, crit_word
    );
`else
    modport master (
        input miss, miss_addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy
    );
    modport slave (
        output miss, miss_addr, mem_ack, mem_rdata,
        input mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy
    );
`endif
endinterface

// File: rtl/icache_line_asm.sv
// icache_line_asm: four-slot word register that assembles a cache line, cleared on reset
module icache_line_asm
    import icache_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  logic [OFFSET_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_WORDS-1:0][WORD_W-1:0] line_nxt
);
    logic [LINE_WORDS-1:0][WORD_W-1:0] slot;
    // next line contents, including the word being written this cycle
    always_comb begin
        line_nxt = slot;
        if (we) line_nxt[idx] = wdata;
    end
    // slot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot <= '0;
        else slot <= line_nxt;
    end
endmodule

// File: rtl/icache_refill.sv
// icache_refill: fetches a 4-word line on a cache miss and strobes it into the cache; ICACHE_REFILL_CWF_EN selects critical-word-first
module icache_refill
    import icache_pkg::*;
(
    input logic clk,
    input logic rst_n,
    icache_refill_if.master bus
);
    state_t state;
    logic [OFFSET_W-1:0] k;
    logic [OFFSET_W-1:0] start;
    logic [OFFSET_W-1:0] idx;
    logic [OFFSET_W-1:0] first;
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] line_nxt;
    logic take;
`ifdef ICACHE_REFILL_CWF_EN
    assign first = bus.miss_addr[OFFSET_LSB +: OFFSET_W];
`else
    assign first = '0;
`endif
    assign idx = start + k;
    assign take = state == FETCH && bus.mem_req && bus.mem_ack;
    icache_line_asm u_asm (
        .clk(clk),
        .rst_n(rst_n),
        .we(take),
        .idx(idx),
        .wdata(bus.mem_rdata),
        .line_nxt(line_nxt)
    );
    // refill FSM; the first FETCH cycle only raises mem_req, giving the fixed 5-cycle zero-wait latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            start <= '0;
            base <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_addr <= '0;
            bus.fill_valid <= 1'b0;
            bus.fill_line <= '0;
            bus.fill_addr <= '0;
            bus.busy <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            bus.crit_valid <= 1'b0;
            bus.crit_word <= '0;
`endif
        end else begin
            bus.fill_valid <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            bus.crit_valid <= 1'b0;
`endif
            case (state)
                IDLE: if (bus.miss) begin
                    base <= bus.miss_addr & LINE_MASK;
                    start <= first;
                    k <= '0;
                    bus.mem_addr <= word_addr(bus.miss_addr & LINE_MASK, first);
                    bus.busy <= 1'b1;
                    state <= FETCH;
                end
                FETCH: if (!bus.mem_req) begin
                    bus.mem_req <= 1'b1;
                end else if (bus.mem_ack) begin
                    k <= k + 2'd1;
`ifdef ICACHE_REFILL_CWF_EN
                    if (k == '0) begin
                        bus.crit_valid <= 1'b1;
                        bus.crit_word <= bus.mem_rdata;
                    end
`endif
                    if (k == OFFSET_W'(LINE_WORDS - 1)) begin
                        bus.mem_req <= 1'b0;
                        bus.fill_valid <= 1'b1;
                        bus.fill_line <= line_nxt;
                        bus.fill_addr <= base;
                        state <= FILL;
                    end else begin
                        bus.mem_addr <= word_addr(base, idx + 2'd1);
                    end
                end
                FILL: begin
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed bench for icache_refill; define ICACHE_REFILL_CWF_EN to cover critical-word-first
module tb_icache_refill;
    logic clk;
    logic rst_n;
    int checks = 0;
    int failures = 0;

    icache_refill_if bus();

    icache_refill dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one full refill; memory answers each request after `waits` idle cycles with rdata = mem_addr ^ salt
    task automatic refill(input string tag, input logic [31:0] maddr, input int waits, input logic [31:0] salt,
                          input int drop_after, input logic [3:0][31:0] exp_a, input logic [127:0] exp_line,
                          input logic [31:0] exp_base, input int exp_lat);
        int w;
        int wc;
        int lat;
        logic acked;
        w = 0;
        wc = 0;
        lat = 0;
        bus.miss = 1'b1;
        bus.miss_addr = maddr;
        tick;
        chk({tag, "/busy"}, bus.busy, 1);
        while (!bus.fill_valid && lat < 64) begin
            acked = 1'b0;
            if (bus.mem_req && w < 4) begin
                chk({tag, "/addr"}, bus.mem_addr, exp_a[w]);
                if (wc == waits) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ salt;
                    acked = 1'b1;
                end else begin
                    wc++;
                end
            end
            tick;
            lat++;
            bus.mem_ack = 1'b0;
            if (acked) begin
                w++;
                wc = 0;
                if (w == drop_after) bus.miss = 1'b0;
            end
`ifdef ICACHE_REFILL_CWF_EN
            chk({tag, "/crit_valid"}, bus.crit_valid, acked && w == 1);
            if (acked && w == 1) chk({tag, "/crit_word"}, bus.crit_word, exp_a[0] ^ salt);
`endif
        end
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/words"}, w, 4);
        chk({tag, "/fill_valid"}, bus.fill_valid, 1);
        chk({tag, "/fill_addr"}, bus.fill_addr, exp_base);
        chk({tag, "/fill_line"}, bus.fill_line, exp_line);
        chk({tag, "/req_drop"}, bus.mem_req, 0);
    endtask

    // cache drops miss after the fill; strobe must end and the line stay held
    task automatic settle(input string tag, input logic [127:0] exp_line);
        bus.miss = 1'b0;
        tick;
        chk({tag, "/fill_pulse"}, bus.fill_valid, 0);
        chk({tag, "/idle"}, bus.busy, 0);
        chk({tag, "/line_held"}, bus.fill_line, exp_line);
        tick;
        chk({tag, "/no_refill"}, bus.busy, 0);
        chk({tag, "/no_fill"}, bus.fill_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.miss = 1'b0;
        bus.miss_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        tick;
        tick;
        chk("reset/req", bus.mem_req, 0);
        chk("reset/busy", bus.busy, 0);
        chk("reset/fill_valid", bus.fill_valid, 0);
        chk("reset/mem_addr", bus.mem_addr, 0);
        chk("reset/fill_addr", bus.fill_addr, 0);
        chk("reset/fill_line", bus.fill_line, 0);
        rst_n = 1'b1;
        tick;

        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick;
        bus.mem_ack = 1'b0;
        chk("stray_ack/req", bus.mem_req, 0);
        chk("stray_ack/busy", bus.busy, 0);

        refill("zero_wait", 32'h0000_0100, 0, 32'h0000_0100, 5,
               {32'h10C, 32'h108, 32'h104, 32'h100},
               128'h0000000c_00000008_00000004_00000000, 32'h100, 5);
        settle("zero_wait", 128'h0000000c_00000008_00000004_00000000);

        refill("wait3", 32'h0000_2000, 3, 32'hA5A5_0000, 5,
               {32'h200C, 32'h2008, 32'h2004, 32'h2000},
               128'hA5A5200C_A5A52008_A5A52004_A5A52000, 32'h2000, 17);
        settle("wait3", 128'hA5A5200C_A5A52008_A5A52004_A5A52000);

`ifdef ICACHE_REFILL_CWF_EN
        refill("unaligned", 32'h0000_010E, 1, 32'hFFFF_0000, 5,
               {32'h108, 32'h104, 32'h100, 32'h10C},
               128'hFFFF010C_FFFF0108_FFFF0104_FFFF0100, 32'h100, 9);
`else
        refill("unaligned", 32'h0000_010E, 1, 32'hFFFF_0000, 5,
               {32'h10C, 32'h108, 32'h104, 32'h100},
               128'hFFFF010C_FFFF0108_FFFF0104_FFFF0100, 32'h100, 9);
`endif
        settle("unaligned", 128'hFFFF010C_FFFF0108_FFFF0104_FFFF0100);

        refill("miss_drop", 32'h4000_0000, 0, 32'h1234_5678, 2,
               {32'h4000000C, 32'h40000008, 32'h40000004, 32'h40000000},
               128'h52345674_52345670_5234567C_52345678, 32'h4000_0000, 5);
        settle("miss_drop", 128'h52345674_52345670_5234567C_52345678);

        bus.miss = 1'b1;
        bus.miss_addr = 32'h0000_0100;
        tick;
        tick;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_0000;
        tick;
        bus.mem_rdata = 32'hDEAD_0004;
        tick;
        bus.mem_ack = 1'b0;
        chk("rst_mid/pre_addr", bus.mem_addr, 32'h108);
        rst_n = 1'b0;
        bus.miss = 1'b0;
        #1;
        chk("rst_mid/req", bus.mem_req, 0);
        chk("rst_mid/busy", bus.busy, 0);
        chk("rst_mid/mem_addr", bus.mem_addr, 0);
        chk("rst_mid/fill_addr", bus.fill_addr, 0);
        chk("rst_mid/fill_line", bus.fill_line, 0);
        chk("rst_mid/fill_valid", bus.fill_valid, 0);
        tick;
        chk("rst_mid/no_fill", bus.fill_valid, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rst_mid/idle", bus.busy, 0);
        chk("rst_mid/no_fill_after", bus.fill_valid, 0);
        refill("after_rst", 32'h0000_0200, 0, 32'h0, 5,
               {32'h20C, 32'h208, 32'h204, 32'h200},
               128'h0000020C_00000208_00000204_00000200, 32'h200, 5);
        settle("after_rst", 128'h0000020C_00000208_00000204_00000200);

        refill("b2b_first", 32'h0000_0280, 0, 32'h0, 5,
               {32'h28C, 32'h288, 32'h284, 32'h280},
               128'h0000028C_00000288_00000284_00000280, 32'h280, 5);
        bus.miss_addr = 32'h0000_0300;
        tick;
        chk("b2b/idle_gap", bus.busy, 0);
        chk("b2b/fill_pulse", bus.fill_valid, 0);
        refill("b2b_second", 32'h0000_0300, 0, 32'h0, 5,
               {32'h30C, 32'h308, 32'h304, 32'h300},
               128'h0000030C_00000308_00000304_00000300, 32'h300, 5);
        settle("b2b_second", 128'h0000030C_00000308_00000304_00000300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
